// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: two-stage pipelined carry-lookahead adder/subtractor
// with valid/ready handshaking on both sides.
// Stage 1 conditions B and forms per-bit and per-group generate/propagate.
// Stage 2 resolves the group carries by lookahead, ripples inside each group,
// and registers SUM and the Cout/V/Z/N flags.
// Optional feature: define CLA_SATURATE_EN to add the SAT input, which clamps
// SUM to the most positive/negative value on signed overflow.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
`ifdef CLA_SATURATE_EN
  input  logic             SAT,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  // stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic [NG-1:0]    s1_gg_q, s1_gg_d;
  logic [NG-1:0]    s1_gp_q, s1_gp_d;
  logic             s1_sub_q, s1_sub_d;
  logic             s1_sat_q, s1_sat_d;

  // stage 2 state (drives the outputs directly)
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             n_q, n_d;

  // stage 1 combinational datapath
  logic [WIDTH-1:0] b_cond, p_bit, g_bit;
  logic [NG-1:0]    grp_g, grp_p;
  logic             s1_sat_in;

  // stage 2 combinational datapath
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] c_bit;
  logic [WIDTH-1:0] sum_raw, sum_n;
  logic             v_n;
  logic             la_acc, la_prod;

  // handshake
  logic s1_advance;

  // operand bits only partly consumed downstream, gathered so lint sees them used
  logic unused_bits;
  assign unused_bits = ^{s1_a_q[MSB-1:0], s1_b_q[MSB-1:0], s1_g_q};

  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;

  assign out_valid = s2_valid_q;
  assign SUM       = sum_q;
  assign Cout      = cout_q;
  assign V         = v_q;
  assign Z         = z_q;
  assign N         = n_q;

`ifdef CLA_SATURATE_EN
  assign s1_sat_in = SAT;
`else
  assign s1_sat_in = 1'b0;
`endif

  // condition B for subtraction and build per-bit / per-group generate-propagate
  always_comb begin
    b_cond = B ^ {WIDTH{SUB}};
    p_bit  = A ^ b_cond;
    g_bit  = A & b_cond;
    grp_g  = '0;
    grp_p  = '0;
    for (int i = 0; i < NG; i++) begin
      grp_g[i] = 1'b0;
      grp_p[i] = 1'b1;
      for (int k = 0; k < GROUP; k++) begin
        grp_g[i] = g_bit[i*GROUP+k] | (p_bit[i*GROUP+k] & grp_g[i]);
        grp_p[i] = grp_p[i] & p_bit[i*GROUP+k];
      end
    end
  end

  // stage 1 loads whenever the block is ready, holds otherwise
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_gg_d    = s1_gg_q;
    s1_gp_d    = s1_gp_q;
    s1_sub_d   = s1_sub_q;
    s1_sat_d   = s1_sat_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = A;
        s1_b_d   = b_cond;
        s1_p_d   = p_bit;
        s1_g_d   = g_bit;
        s1_gg_d  = grp_g;
        s1_gp_d  = grp_p;
        s1_sub_d = SUB;
        s1_sat_d = s1_sat_in;
      end
    end
  end

  // stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_gg_q    <= '0;
      s1_gp_q    <= '0;
      s1_sub_q   <= 1'b0;
      s1_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_p_q     <= s1_p_d;
      s1_g_q     <= s1_g_d;
      s1_gg_q    <= s1_gg_d;
      s1_gp_q    <= s1_gp_d;
      s1_sub_q   <= s1_sub_d;
      s1_sat_q   <= s1_sat_d;
    end
  end

  // flat lookahead over group G/P, then ripple inside each group, then flags
  always_comb begin
    grp_c    = '0;
    c_bit    = '0;
    la_acc   = 1'b0;
    la_prod  = 1'b0;
    grp_c[0] = s1_sub_q;
    for (int i = 0; i < NG; i++) begin
      la_acc  = s1_gg_q[i];
      la_prod = s1_gp_q[i];
      for (int j = i - 1; j >= 0; j--) begin
        la_acc  = la_acc | (la_prod & s1_gg_q[j]);
        la_prod = la_prod & s1_gp_q[j];
      end
      grp_c[i+1] = la_acc | (la_prod & s1_sub_q);
    end
    for (int i = 0; i < NG; i++) begin
      for (int k = 0; k < GROUP; k++) begin
        if (k == 0) begin
          c_bit[i*GROUP] = grp_c[i];
        end else begin
          c_bit[i*GROUP+k] = s1_g_q[i*GROUP+k-1] |
                             (s1_p_q[i*GROUP+k-1] & c_bit[i*GROUP+k-1]);
        end
      end
    end
    sum_raw = s1_p_q ^ c_bit;
    v_n     = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum_raw[MSB] != s1_a_q[MSB]);
    sum_n   = sum_raw;
    if (s1_sat_q && v_n) begin
      sum_n = s1_a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // stage 2 takes stage 1 when empty or being consumed, holds during a stall
  always_comb begin
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    v_d        = v_q;
    z_d        = z_q;
    n_d        = n_q;
    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d  = sum_n;
        cout_d = grp_c[NG];
        v_d    = v_n;
        z_d    = (sum_n == '0);
        n_d    = sum_n[MSB];
      end
    end
  end

  // stage 2 / output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      v_q        <= 1'b0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      v_q        <= v_d;
      z_q        <= z_d;
      n_q        <= n_d;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Testbench for pipelined_cla_addsub (WIDTH=16, GROUP=4).
// A negedge monitor pushes a model result for every accepted operand set and
// pops/compares on every consumed result; scenario tasks add inline checks.
module tb_pipelined_cla_addsub;

  localparam int WIDTH = 16;
  localparam int GROUP = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        SUB = 1'b0;
  logic        sat_drv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] SUM;
  logic        Cout, V, Z, N;

  int   vectors = 0;
  int   miscompares = 0;
  int   outputs_seen = 0;
  res_t exp_q[$];
  res_t mon_exp;

  pipelined_cla_addsub #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .SUB(SUB),
`ifdef CLA_SATURATE_EN
    .SAT(sat_drv),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .SUM(SUM),
    .Cout(Cout),
    .V(V),
    .Z(Z),
    .N(N)
  );

  always #5 clk = ~clk;

  // reference model: 17-bit sum for Cout, integer range test for overflow
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic sat);
    logic [16:0] full;
    int          sa, sb, sr;
    res_t        r;
    full = {1'b0, a} + (sub ? ({1'b0, ~b} + 17'd1) : {1'b0, b});
    sa = $signed(a);
    sb = $signed(b);
    sr = sub ? (sa - sb) : (sa + sb);
    r.sum  = full[15:0];
    r.cout = full[16];
    r.v    = (sr > 32767) || (sr < -32768);
    if (sat && r.v) r.sum = (sr > 0) ? 16'h7FFF : 16'h8000;
    r.z = (r.sum == 16'h0000);
    r.n = r.sum[15];
    return r;
  endfunction

  // scoreboard: push on accept, pop and compare on consume
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back(model(A, B, SUB, sat_drv));
      if (out_valid && out_ready) begin
        vectors++;
        outputs_seen++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_result: got SUM=%h, required no output", SUM);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({SUM, Cout, V, Z, N} !== mon_exp) begin
            miscompares++;
            $display("[TB] FAIL result: got SUM=%h C=%b V=%b Z=%b N=%b, required SUM=%h C=%b V=%b Z=%b N=%b",
                     SUM, Cout, V, Z, N, mon_exp.sum, mon_exp.cout, mon_exp.v, mon_exp.z, mon_exp.n);
          end
        end
      end
    end
  end

  // present one operand set and hold it until accepted (called at posedge+1)
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic sat);
    int budget;
    budget = 0;
    A = a; B = b; SUB = sub; sat_drv = sat; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: got in_ready=%b, required 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // wait until every expected result has been consumed
  task automatic drain();
    int budget;
    budget = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
    vectors++; if (SUM !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_sum: got %h, required 0000", SUM); end
    vectors++; if ({Cout, V, Z, N} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b, required 0000", {Cout, V, Z, N}); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    // first accept on the first rising edge after release: wrap-around case
    A = 16'hFFFF; B = 16'h0001; SUB = 1'b0; sat_drv = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL first_accept: got in_ready=%b, required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({out_valid, SUM, Cout, Z, V} !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL wrap_around: got valid=%b SUM=%h C=%b Z=%b V=%b, required 1 0000 1 1 0",
               out_valid, SUM, Cout, Z, V);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_latency();
    A = 16'h1234; B = 16'h0FED; SUB = 1'b0; sat_drv = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_early: got out_valid=%b, required 0", out_valid); end
    @(negedge clk);
    vectors++;
    if ({out_valid, SUM, Cout, V, Z, N} !== {1'b1, 16'h2221, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL latency_result: got valid=%b SUM=%h flags=%b, required 1 2221 0000",
               out_valid, SUM, {Cout, V, Z, N});
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_directed();
    send(16'h0005, 16'h0007, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    send(16'h1234, 16'h1234, 1'b1, 1'b0);
`ifdef CLA_SATURATE_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    send(16'h8000, 16'hFFFF, 1'b0, 1'b1);
    send(16'h1000, 16'h0001, 1'b0, 1'b1);
`endif
    drain();
  endtask

  task automatic test_back_to_back();
    int   start_seen;
    logic ready_dropped;
    logic stalled_prev;
    logic [20:0] held;
    start_seen    = outputs_seen;
    ready_dropped = 1'b0;
    stalled_prev  = 1'b0;
    held          = '0;
    out_ready     = 1'b1;
    fork
      begin
        send(16'h0001, 16'h0002, 1'b0, 1'b0);
        send(16'h0100, 16'h0033, 1'b1, 1'b0);
        send(16'hABCD, 16'h1111, 1'b0, 1'b0);
        send(16'h4000, 16'h4000, 1'b0, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (!in_ready) ready_dropped = 1'b1;
          if (stalled_prev) begin
            vectors++;
            if ({out_valid, SUM, Cout, V, Z, N} !== held) begin
              miscompares++;
              $display("[TB] FAIL stall_stable: got %h, required %h", {out_valid, SUM, Cout, V, Z, N}, held);
            end
          end
          stalled_prev = out_valid && !out_ready;
          held = {out_valid, SUM, Cout, V, Z, N};
        end
      end
    join
    drain();
    vectors++; if (ready_dropped !== 1'b1) begin miscompares++; $display("[TB] FAIL in_ready_drop: got never low, required low while full"); end
    vectors++;
    if (outputs_seen - start_seen != 4) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d results, required 4", outputs_seen - start_seen);
    end
  endtask

  task automatic test_random();
    logic done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
`ifdef CLA_SATURATE_EN
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
`else
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
`endif
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_midflight();
    int seen;
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h0001, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL midflight_full: got out_valid=%b, required 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL async_clear: got out_valid=%b, required 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL async_in_ready: got %b, required 1", in_ready); end
    vectors++; if (SUM !== 16'h0000) begin miscompares++; $display("[TB] FAIL async_sum: got %h, required 0000", SUM); end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("[TB] FAIL stale_result: got %0d outputs, required 0", seen); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
